mdu_ctrl: RTL and testbench

Multi-cycle multiply/divide controller that sequences the MDU for the E stage and owns the HI/LO registers. It accepts MDU operations from E, models the mult/div latency with a down-counter, and produces the stall consumed by the hazard unit. It also drives the MDU read value that the MDU inputs of the forwarding and write-back selectors consume.

---
 rtl/mdu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mdu_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: owns HI/LO, times MDU latency, raises E-stage stall.
// Optional MDU_MADD_EN enables madd/maddu/msub/msubu (ops 9-12).
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        use_D,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDUout
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
  typedef enum logic [1:0] {CM_LOAD, CM_KEEP, CM_ADD, CM_SUB} commit_e;

  state_e             state_q, state_d;
  commit_e            cmode_q, cmode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        pend_q, pend_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;

  logic is_mult, is_div, is_macc, is_move, is_arith, accept;
  logic signed_op, a_neg, b_neg;
  logic [63:0] a_ext, b_ext, prod;
  logic [31:0] abs_a, abs_b, divisor, q_u, r_u, quot, rem;

  // Op decode and accept qualification
  always_comb begin
    is_mult   = (op == OP_MULT) || (op == OP_MULTU);
    is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    is_move   = (op >= OP_MTHI) && (op <= OP_MFLO);
    signed_op = (op == OP_MULT) || (op == OP_DIV);
`ifdef MDU_MADD_EN
    is_macc   = (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    signed_op = signed_op || (op == OP_MADD) || (op == OP_MSUB);
`else
    is_macc   = 1'b0;
`endif
    is_arith  = is_mult || is_div || is_macc;
    accept    = start && !flush && (state_q == ST_IDLE) && (is_arith || is_move);
  end

  // 64-bit product, two's-complement wrap gives the signed result when operands are sign-extended
  always_comb begin
    a_ext = signed_op ? {{32{A[31]}}, A} : {32'h0, A};
    b_ext = signed_op ? {{32{B[31]}}, B} : {32'h0, B};
    prod  = a_ext * b_ext;
  end

  // Sign-magnitude divide; 0x80000000 / -1 falls out as quotient 0x80000000, remainder 0
  always_comb begin
    a_neg   = (op == OP_DIV) && A[31];
    b_neg   = (op == OP_DIV) && B[31];
    abs_a   = a_neg ? (32'h0 - A) : A;
    abs_b   = b_neg ? (32'h0 - B) : B;
    divisor = (B == 32'h0) ? 32'h1 : abs_b;
    q_u     = abs_a / divisor;
    r_u     = abs_a % divisor;
    quot    = (a_neg ^ b_neg) ? (32'h0 - q_u) : q_u;
    rem     = a_neg ? (32'h0 - r_u) : r_u;
  end

  // Next-state: accept, count down, commit on the 1->0 edge
  always_comb begin
    state_d = state_q;
    cmode_d = cmode_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_arith) begin
            state_d = ST_BUSY;
            cnt_d   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_d  = is_div ? {rem, quot} : prod;
            if (is_div && (B == 32'h0)) begin
              cmode_d = CM_KEEP;
            end else begin
              cmode_d = CM_LOAD;
`ifdef MDU_MADD_EN
              if ((op == OP_MADD) || (op == OP_MADDU)) cmode_d = CM_ADD;
              if ((op == OP_MSUB) || (op == OP_MSUBU)) cmode_d = CM_SUB;
`endif
            end
          end else if (op == OP_MTHI) begin
            hi_d = A;
          end else if (op == OP_MTLO) begin
            lo_d = A;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          case (cmode_q)
            CM_LOAD: {hi_d, lo_d} = pend_q;
`ifdef MDU_MADD_EN
            CM_ADD:  {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
            CM_SUB:  {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
`endif
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmode_q <= CM_LOAD;
      cnt_q   <= '0;
      pend_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cmode_q <= cmode_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy   = (state_q == ST_BUSY);
  assign stall  = use_D && (busy || (start && is_arith)) && !reset;
  assign HI     = hi_q;
  assign LO     = lo_q;
  assign MDUout = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : 32'h0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl (default MULT_CYCLES=5, DIV_CYCLES=10).
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, flush, use_D;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        busy, stall;
  logic [31:0] HI, LO, MDUout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .start(start), .flush(flush),
    .A(A), .B(B), .use_D(use_D), .busy(busy), .stall(stall),
    .HI(HI), .LO(LO), .MDUout(MDUout)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; start = 1'b1; A = a; B = b;
    tick();
    op = 4'd0; start = 1'b0;
  endtask

  task automatic wait_busy(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      tick();
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; op = 4'd1; flush = 1'b0; use_D = 1'b1;
    A = 32'h0; B = 32'h0;
    tick();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    start = 1'b0; op = 4'd0; use_D = 1'b0;
    #1;
    chk("rst_mduout", MDUout, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    // mult -2 * 3
    issue(4'd1, 32'hFFFF_FFFE, 32'd3);
    wait_busy(5, "mult");
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFFA);

    // mthi/mtlo then divu by zero keeps HI/LO
    issue(4'd5, 32'h1234, 32'h0);
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    issue(4'd6, 32'h5678, 32'h0);
    chk("mtlo_lo", LO, 32'h5678);
    issue(4'd4, 32'd7, 32'd0);
    wait_busy(10, "divu0");
    chk("divu0_hi", HI, 32'h1234);
    chk("divu0_lo", LO, 32'h5678);

    // div -7 / 2 with use_D held high
    use_D = 1'b1; op = 4'd3; start = 1'b1; A = 32'hFFFF_FFF9; B = 32'd2;
    #1;
    chk("div_stall_start", 32'(stall), 32'd1);
    tick();
    op = 4'd0; start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk("div_busy", 32'(busy), 32'd1);
      chk("div_stall_busy", 32'(stall), 32'd1);
      tick();
    end
    chk("div_idle", 32'(busy), 32'd0);
    chk("div_stall_after", 32'(stall), 32'd0);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    use_D = 1'b0;

    // back-to-back: multu in the first idle cycle
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_busy(5, "multu");
    chk("multu_hi", HI, 32'h1);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // start+flush: not accepted, stall still follows its equation
    use_D = 1'b1; flush = 1'b1; op = 4'd1; start = 1'b1; A = 32'd5; B = 32'd5;
    #1;
    chk("flush_stall", 32'(stall), 32'd1);
    tick();
    flush = 1'b0; start = 1'b0; op = 4'd0; use_D = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_hi", HI, 32'h1);
    chk("flush_lo", LO, 32'hFFFF_FFFE);
    issue(4'd5, 32'hAA, 32'h0);
    op = 4'd7; start = 1'b1;
    #1;
    chk("mfhi", MDUout, 32'hAA);
    op = 4'd8;
    #1;
    chk("mflo", MDUout, 32'hFFFF_FFFE);
    tick();
    op = 4'd0; start = 1'b0;
    #1;
    chk("mfx_busy", 32'(busy), 32'd0);
    chk("mduout_none", MDUout, 32'h0);

    // signed overflow divide
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_busy(10, "divovf");
    chk("divovf_lo", LO, 32'h8000_0000);
    chk("divovf_hi", HI, 32'h0);

    // reset in the 3rd busy cycle of a div
    issue(4'd5, 32'hAA, 32'h0);
    issue(4'd3, 32'd100, 32'd7);
    tick();
    tick();
    chk("rstmid_busy", 32'(busy), 32'd1);
    reset = 1'b1; use_D = 1'b1;
    #1;
    chk("rstmid_stall_in", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("rstmid_busy_after", 32'(busy), 32'd0);
    chk("rstmid_hi", HI, 32'h0);
    chk("rstmid_lo", LO, 32'h0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    use_D = 1'b0;
    repeat (12) tick();
    chk("rstmid_late_hi", HI, 32'h0);
    chk("rstmid_late_lo", LO, 32'h0);

    // start while busy is dropped
    issue(4'd1, 32'd3, 32'd3);
    op = 4'd5; start = 1'b1; A = 32'hDEAD;
    tick();
    op = 4'd0; start = 1'b0;
    wait_busy(4, "drop");
    chk("drop_hi", HI, 32'h0);
    chk("drop_lo", LO, 32'd9);

`ifdef MDU_MADD_EN
    issue(4'd6, 32'd10, 32'h0);
    issue(4'd9, 32'd3, 32'd4);
    wait_busy(5, "madd");
    chk("madd_hi", HI, 32'h0);
    chk("madd_lo", LO, 32'd22);
    issue(4'd12, 32'd1, 32'd30);
    wait_busy(5, "msubu");
    chk("msubu_hi", HI, 32'hFFFF_FFFF);
    chk("msubu_lo", LO, 32'hFFFF_FFF8);
`else
    use_D = 1'b1; op = 4'd9; start = 1'b1; A = 32'd3; B = 32'd4;
    #1;
    chk("nomadd_stall", 32'(stall), 32'd0);
    tick();
    op = 4'd0; start = 1'b0; use_D = 1'b0;
    chk("nomadd_busy", 32'(busy), 32'd0);
    chk("nomadd_lo", LO, 32'd9);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
